csa_resolve9: RTL and testbench

CSA_RESOLVE9 -- requirements
Module: csa_resolve9

---
 rtl/csa_resolve9.sv | 133 +++++++++++++
 tb/tb_csa_resolve9.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve9.sv
// csa_resolve9 -- resolves a 9-bit carry-save pair (Sum, Carry) into a
// non-redundant value with a small sequential ripple adder that handles
// one 3-bit slice per clock.
//
// Ports
//   clk    : rising-edge clock for all state
//   reset  : synchronous, active-high reset
//   start  : request to resolve the presented operand pair (ignored while busy)
//   Sum    : 9-bit sum vector of the carry-save residual
//   Carry  : 9-bit carry vector, already weight-aligned (Carry[0] normally 0)
//   Result : (Sum + Carry) mod 2^9, updated only when a resolution completes
//   cout   : carry out of bit 8 for the last completed resolution
//   sign   : Result[8]
//   zero   : high when the last completed Result is 9'h000
//   busy   : high while slices are being added
//   done   : one-cycle pulse when Result/cout/sign/zero are fresh
module csa_resolve9 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] Sum,
  input  logic [8:0] Carry,
  output logic [8:0] Result,
  output logic       cout,
  output logic       sign,
  output logic       zero,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [1:0] cnt;
  logic       cy;
  logic [8:0] sum_r;
  logic [8:0] carry_r;
  logic [8:0] acc;

  logic [2:0] a_sl;
  logic [2:0] b_sl;
  logic [3:0] sl;
  logic [8:0] acc_next;
  logic       accept;

  // New operands are taken only when no resolution is in flight.
  assign accept = start && ((state == IDLE) || (state == DONE));

  assign busy = (state == ADD);
  assign done = (state == DONE);
  assign sign = Result[8];

  // Slice adder: picks the slice addressed by cnt and merges its 3-bit sum
  // into a copy of the accumulator.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    a_sl     = sum_r[2:0];
    b_sl     = carry_r[2:0];
    acc_next = acc;
    case (cnt)
      2'd1: begin
        a_sl = sum_r[5:3];
        b_sl = carry_r[5:3];
      end
      2'd2: begin
        a_sl = sum_r[8:6];
        b_sl = carry_r[8:6];
      end
      default: ;
    endcase
    sl = {1'b0, a_sl} + {1'b0, b_sl} + {3'b000, cy};
    case (cnt)
      2'd1:    acc_next[5:3] = sl[2:0];
      2'd2:    acc_next[8:6] = sl[2:0];
      default: acc_next[2:0] = sl[2:0];
    endcase
  end

  // Operand capture. These are pure datapath holding registers: they are
  // always written before use, so they carry no reset.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (accept) begin
      sum_r   <= Sum;
      carry_r <= Carry;
    end
  end

  // Control FSM plus accumulator and visible result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      cy     <= 1'b0;
      acc    <= 9'h000;
      Result <= 9'h000;
      cout   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state <= ADD;
            cnt   <= 2'd0;
            cy    <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        ADD: begin
          acc <= acc_next;
          cy  <= sl[3];
          cnt <= cnt + 2'd1;
          if (cnt == 2'd2) begin
            // Last slice: publish the completed value. The final carry goes
            // only to cout; it never wraps back into bit 0.
            Result <= acc_next;
            cout   <= sl[3];
            zero   <= (acc_next == 9'h000);
            cnt    <= 2'd0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolve9.sv
// tb_csa_resolve9 -- self-checking bench for csa_resolve9. Expected values
// come from plain integer addition of the operands (10-bit reference sum).
module tb_csa_resolve9;

  logic       clk;
  logic       reset;
  logic       start;
  logic [8:0] sum;
  logic [8:0] carry;
  logic [8:0] result;
  logic       cout;
  logic       sign;
  logic       zero;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_bad;

  // Reference state: last completed result as the model sees it.
  int last_res;
  int last_cout;
  int last_zero;

  csa_resolve9 dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .Sum    (sum),
    .Carry  (carry),
    .Result (result),
    .cout   (cout),
    .sign   (sign),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: unsigned 10-bit sum of the two operands.
  task automatic model(input int s, input int c);
    int full;
    full      = s + c;
    last_res  = full % 512;
    last_cout = full / 512;
    last_zero = (last_res == 0) ? 1 : 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".result"}, int'(result), last_res);
    check({tag, ".cout"},   int'(cout),   last_cout);
    check({tag, ".sign"},   int'(sign),   last_res / 256);
    check({tag, ".zero"},   int'(zero),   last_zero);
  endtask

  // Launch one resolution, scramble the inputs while it runs, and check
  // latency, busy, result hold, and the completed outputs.
  task automatic run_op(input logic [8:0] s, input logic [8:0] c,
                        input string tag, input bit full_check);
    int edges;
    int prev_res;
    prev_res = last_res;
    @(negedge clk);
    start = 1'b1;
    sum   = s;
    carry = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    sum   = 9'($urandom);
    carry = 9'($urandom);
    edges = 1;
    if (full_check) begin
      check({tag, ".busy"}, int'(busy), 1);
      check({tag, ".hold"}, int'(result), prev_res);
    end
    while (!done && edges < 12) begin
      @(posedge clk);
      #1;
      edges++;
    end
    model(int'(s), int'(c));
    if (full_check || edges != 4) check({tag, ".latency"}, edges, 4);
    check_outputs(tag);
    @(posedge clk);
    #1;
    if (full_check) begin
      check({tag, ".done_drop"}, int'(done), 0);
      check({tag, ".idle_busy"}, int'(busy), 0);
    end
  endtask

  initial begin
    int edges;
    int done_seen;
    logic [8:0] s1, c1, s2, c2;

    n_cmp    = 0;
    n_bad    = 0;
    last_res = 0; last_cout = 0; last_zero = 0;
    reset    = 1'b1;
    start    = 1'b1;
    sum      = 9'h1FF;
    carry    = 9'h1FF;

    // Reset overrides start.
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check_outputs("rst");
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases, including slice-boundary carries.
    run_op(9'h0FF, 9'h001, "d_0ff", 1'b1);
    run_op(9'h1FF, 9'h001, "d_1ff", 1'b1);
    run_op(9'h007, 9'h001, "d_007", 1'b1);
    run_op(9'h03F, 9'h001, "d_03f", 1'b1);
    run_op(9'h1FE, 9'h1FE, "d_max", 1'b1);

    // start held through ADD with operands changing mid-flight, then a
    // back-to-back operation accepted in the DONE cycle.
    s1 = 9'h123; c1 = 9'h0D4;
    s2 = 9'h0F0; c2 = 9'h10E;
    @(negedge clk);
    start = 1'b1; sum = s1; carry = c1;
    @(posedge clk);
    #1;
    sum = s2; carry = c2;
    edges = 1;
    done_seen = 0;
    while (!done && edges < 12) begin
      @(posedge clk);
      #1;
      edges++;
    end
    model(int'(s1), int'(c1));
    check("b2b.lat1", edges, 4);
    check_outputs("b2b.op1");
    // Still start=1: this edge captures s2/c2.
    @(posedge clk);
    #1;
    start = 1'b0;
    sum = 9'h000; carry = 9'h000;
    check("b2b.busy2", int'(busy), 1);
    edges = 1;
    while (!done && edges < 12) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("b2b.lat2", edges, 4);
    model(int'(s2), int'(c2));
    check_outputs("b2b.op2");
    @(posedge clk);
    #1;

    // Reset during the 2nd ADD cycle aborts the operation.
    @(negedge clk);
    start = 1'b1; sum = 9'h155; carry = 9'h0AA;
    @(posedge clk);        // capture
    #1;
    start = 1'b0;
    @(posedge clk);        // slice 0; now in the 2nd ADD cycle
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_res = 0; last_cout = 0; last_zero = 0;
    check("abort.busy", int'(busy), 0);
    check_outputs("abort");
    done_seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) done_seen = 1;
    end
    check("abort.no_done", done_seen, 0);
    check("abort.result_kept", int'(result), 0);
    run_op(9'h0AA, 9'h055, "post_abort", 1'b1);

    // Randomized operand pairs against the 10-bit reference sum.
    for (int i = 0; i < 1000; i++) begin
      run_op(9'($urandom), 9'($urandom), "rand", (i < 20));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
